// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding, halt marker and word geometry.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_ACK   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/instr_loader_if.sv
// Bus bundle between the RX FIFO, the loader and instruction memory.
interface instr_loader_if #(
    parameter int N_DATA  = 8,
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
);
    // FIFO side is first-word-fall-through: din is valid whenever empty=0, and a
    // one-cycle read_tx pops it. Memory side: a write happens in each cycle with imem_wr_en=1.
    logic [N_DATA-1:0]  din;
    logic               empty;
    logic               read_tx;
    logic               finish_send;
    logic               imem_wr_en;
    logic [NB_ADDR-1:0] imem_addr;
    logic [NB_DATA-1:0] imem_wr_data;

    modport master (
        input  din, empty,
        output read_tx, finish_send, imem_wr_en, imem_addr, imem_wr_data
    );

    modport slave (
        output din, empty,
        input  read_tx, finish_send, imem_wr_en, imem_addr, imem_wr_data
    );

endinterface

// File: rtl/instr_loader_byte_assembler.sv
// Collects bytes little-endian into one word; word_ready flags the load that fills the last lane.
module byte_assembler
    import loader_pkg::*;
#(
    parameter int N_DATA  = 8,
    parameter int NB_DATA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [N_DATA-1:0]  din,
    output logic [NB_DATA-1:0] word,
    output logic               word_ready
);

    localparam int                LANES    = BYTES_PER_WORD;
    localparam int                IDX_W    = $clog2(LANES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LANES - 1);

    logic [IDX_W-1:0] byte_idx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (load) begin
            for (int i = 0; i < LANES; i++) begin
                if (byte_idx == IDX_W'(i)) begin
                    word[i*N_DATA +: N_DATA] <= din;
                end
            end
            byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;
        end
    end

    assign word_ready = load && (byte_idx == LAST_IDX);

endmodule

// File: rtl/instr_loader.sv
// Loads a program from the UART RX FIFO into instruction memory until the halt word.
// Optional LOADER_CHECKSUM_EN adds a running XOR checksum of all written words.
module instr_loader #(
    parameter int                 N_DATA    = 8,
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_ADDR   = 8,
    parameter logic [NB_DATA-1:0] HALT_WORD = loader_pkg::HALT_WORD
) (
    input  logic                clock,
    input  logic                reset,
    instr_loader_if.master      bus,
    output logic [NB_ADDR:0]    word_count,
    output logic                load_done,
    output logic                overflow,
    output logic                pipe_enable,
`ifdef LOADER_CHECKSUM_EN
    output logic [NB_DATA-1:0]  checksum,
    output logic                checksum_valid,
`endif
    output loader_pkg::state_t  dbg_state
);
    import loader_pkg::*;

    state_t             state, state_next;
    logic [NB_ADDR-1:0] addr;
    logic [NB_DATA-1:0] word;
    logic               word_ready;
    logic               is_halt;
    logic               at_last;

    byte_assembler #(.N_DATA(N_DATA), .NB_DATA(NB_DATA)) u_asm (
        .clock      (clock),
        .reset      (reset),
        .load       (state == S_POP),
        .clear      (state == S_WRITE),
        .din        (bus.din),
        .word       (word),
        .word_ready (word_ready)
    );

    assign is_halt = (word == HALT_WORD);
    assign at_last = (addr == '1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // empty is only looked at in S_IDLE, so glitches elsewhere are harmless.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (!bus.empty) state_next = S_POP;
            S_POP:   state_next = word_ready ? S_WRITE : S_ACK;
            S_ACK:   state_next = S_IDLE;
            S_WRITE: state_next = (is_halt || at_last) ? S_DONE : S_IDLE;
            S_DONE:  state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // Halt wins over a full memory: overflow only when the last slot held a non-halt word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr       <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else if (state == S_WRITE) begin
            word_count <= word_count + 1'b1;
            if (!is_halt && at_last)  overflow <= 1'b1;
            if (!is_halt && !at_last) addr     <= addr + 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                 checksum <= '0;
        else if (state == S_WRITE)  checksum <= checksum ^ word;
    end
    assign checksum_valid = load_done;
`endif

    assign bus.read_tx      = (state == S_POP);
    assign bus.finish_send  = (state == S_ACK) || (state == S_WRITE);
    assign bus.imem_wr_en   = (state == S_WRITE);
    assign bus.imem_addr    = addr;
    assign bus.imem_wr_data = word;
    assign load_done        = (state == S_DONE);
    assign pipe_enable      = load_done & ~overflow;
    assign dbg_state        = state;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: an 8-bit-address and a 2-bit-address instance share one FIFO model;
// the one not selected is held in reset.
module tb_instr_loader;
    import loader_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_m = 1'b0;
    logic       reset_s = 1'b0;
    logic       sel     = 1'b0;
    logic [7:0] din     = 8'h00;
    logic       empty   = 1'b1;

    instr_loader_if #(.N_DATA(8), .NB_DATA(32), .NB_ADDR(8)) bus_m ();
    instr_loader_if #(.N_DATA(8), .NB_DATA(32), .NB_ADDR(2)) bus_s ();

    assign bus_m.din   = din;
    assign bus_m.empty = empty;
    assign bus_s.din   = din;
    assign bus_s.empty = empty;

    logic [8:0]  wc_m;
    logic [2:0]  wc_s;
    logic        ld_m, ld_s, ovf_m, ovf_s, pe_m, pe_s;
    state_t      st_m, st_s;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] chk_m, chk_s;
    logic        cv_m, cv_s;
`endif

    instr_loader #(.NB_ADDR(8)) dut_m (
        .clock (clock), .reset (reset_m), .bus (bus_m),
        .word_count (wc_m), .load_done (ld_m), .overflow (ovf_m), .pipe_enable (pe_m),
`ifdef LOADER_CHECKSUM_EN
        .checksum (chk_m), .checksum_valid (cv_m),
`endif
        .dbg_state (st_m)
    );

    instr_loader #(.NB_ADDR(2)) dut_s (
        .clock (clock), .reset (reset_s), .bus (bus_s),
        .word_count (wc_s), .load_done (ld_s), .overflow (ovf_s), .pipe_enable (pe_s),
`ifdef LOADER_CHECKSUM_EN
        .checksum (chk_s), .checksum_valid (cv_s),
`endif
        .dbg_state (st_s)
    );

    // Observed view of whichever instance is selected.
    logic        obs_read, obs_fin, obs_wr, obs_ld, obs_ovf, obs_pe, obs_rst;
    logic [7:0]  obs_addr;
    logic [31:0] obs_data;
    logic [8:0]  obs_wc;
    state_t      obs_state;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] obs_chk;
    logic        obs_cv;
`endif

    always_comb begin
        obs_read  = bus_m.read_tx;
        obs_fin   = bus_m.finish_send;
        obs_wr    = bus_m.imem_wr_en;
        obs_addr  = bus_m.imem_addr;
        obs_data  = bus_m.imem_wr_data;
        obs_wc    = wc_m;
        obs_ld    = ld_m;
        obs_ovf   = ovf_m;
        obs_pe    = pe_m;
        obs_state = st_m;
        obs_rst   = reset_m;
`ifdef LOADER_CHECKSUM_EN
        obs_chk   = chk_m;
        obs_cv    = cv_m;
`endif
        if (sel) begin
            obs_read  = bus_s.read_tx;
            obs_fin   = bus_s.finish_send;
            obs_wr    = bus_s.imem_wr_en;
            obs_addr  = {6'd0, bus_s.imem_addr};
            obs_data  = bus_s.imem_wr_data;
            obs_wc    = {6'd0, wc_s};
            obs_ld    = ld_s;
            obs_ovf   = ovf_s;
            obs_pe    = pe_s;
            obs_state = st_s;
            obs_rst   = reset_s;
`ifdef LOADER_CHECKSUM_EN
            obs_chk   = chk_s;
            obs_cv    = cv_s;
`endif
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model, scoreboard and reference-model state.
    logic [7:0]  fifo_q[$];
    logic [39:0] exp_q[$];
    logic [7:0]  m_bytes[$];
    bit          pending, prev_read;
    int          rd_cnt, fin_cnt, rd_base, fin_base;
    int          m_addr, m_max, m_words, m_consumed, m_left;
    bit          m_done, m_ovf;
    logic [31:0] m_chk;

    // One clock of monitoring; the FIFO head only moves on the falling edge.
    task automatic tick();
        logic [39:0] e;
        @(negedge clock);
        if (!obs_rst) begin
            pending   = 1'b0;
            prev_read = 1'b0;
        end else begin
            if (obs_read) rd_cnt++;
            if (obs_fin)  fin_cnt++;
            if (prev_read) check("ack_after_pop", obs_fin, 1);
            if (obs_wr) begin
                check("wr_with_ack", obs_fin, 1);
                if (exp_q.size() == 0) check("unexpected_write", {obs_addr, obs_data}, 0);
                else begin
                    e = exp_q.pop_front();
                    check("write", {obs_addr, obs_data}, e);
                end
            end
            if (pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
            pending   = obs_read;
            prev_read = obs_read;
        end
        empty = (fifo_q.size() == 0);
        din   = empty ? 8'h00 : fifo_q[0];
    endtask

    // Reference: bytes group 4 at a time little-endian; loading stops at halt or a full memory.
    task automatic model_feed(input logic [7:0] b);
        logic [31:0] w;
        if (m_done) begin
            m_left++;
            return;
        end
        m_consumed++;
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
            w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            m_bytes.delete();
            exp_q.push_back({8'(m_addr), w});
            m_words++;
            m_chk ^= w;
            if (w == 32'hFFFF_FFFF) m_done = 1'b1;
            else if (m_addr == m_max) begin
                m_done = 1'b1;
                m_ovf  = 1'b1;
            end else m_addr++;
        end
    endtask

    task automatic do_reset(input bit use_small);
        reset_m = 1'b0;
        reset_s = 1'b0;
        sel     = use_small;
        fifo_q.delete();
        exp_q.delete();
        m_bytes.delete();
        pending = 1'b0; prev_read = 1'b0;
        m_addr = 0; m_max = use_small ? 3 : 255; m_words = 0; m_consumed = 0; m_left = 0;
        m_done = 1'b0; m_ovf = 1'b0; m_chk = '0;
        rd_base = rd_cnt; fin_base = fin_cnt;
        tick(); tick();
        check("rst_read", obs_read, 0);
        check("rst_fin", obs_fin, 0);
        check("rst_wr", obs_wr, 0);
        check("rst_addr", obs_addr, 0);
        check("rst_data", obs_data, 0);
        check("rst_wc", obs_wc, 0);
        check("rst_done", obs_ld, 0);
        check("rst_ovf", obs_ovf, 0);
        check("rst_pe", obs_pe, 0);
        check("rst_state", obs_state, S_IDLE);
`ifdef LOADER_CHECKSUM_EN
        check("rst_chk", obs_chk, 0);
`endif
        if (use_small) reset_s = 1'b1;
        else           reset_m = 1'b1;
        tick();
    endtask

    task automatic send(input logic [7:0] bq[$]);
        int n;
        foreach (bq[i]) begin
            model_feed(bq[i]);
            fifo_q.push_back(bq[i]);
            repeat ($urandom_range(0, 4)) tick();
        end
        n = 0;
        while (!(fifo_q.size() == m_left && exp_q.size() == 0 && !pending &&
                 (obs_state == S_IDLE || obs_state == S_DONE)) && n < 600) begin
            tick();
            n++;
        end
        check("drain_timeout", n < 600, 1);
        repeat (4) tick();
    endtask

    task automatic end_checks();
        check("reads", rd_cnt - rd_base, m_consumed);
        check("acks", fin_cnt - fin_base, m_consumed);
        check("word_count", obs_wc, m_words);
        check("load_done", obs_ld, m_done);
        check("overflow", obs_ovf, m_ovf);
        check("pipe_enable", obs_pe, m_done && !m_ovf);
        check("fifo_left", fifo_q.size(), m_left);
`ifdef LOADER_CHECKSUM_EN
        check("checksum", obs_chk, m_chk);
        check("checksum_valid", obs_cv, m_done);
`endif
    endtask

    function automatic void push_word(ref logic [7:0] bq[$], input logic [31:0] w);
        for (int i = 0; i < 4; i++) bq.push_back(w[8*i +: 8]);
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [3:0]  mask;
        w = $urandom;
        if ($urandom_range(0, 2) == 0) begin
            mask = 4'($urandom_range(1, 14));
            for (int i = 0; i < 4; i++) if (mask[i]) w[8*i +: 8] = 8'hFF;
        end
        return w;
    endfunction

    initial begin
        logic [7:0] bq[$];
        int nw;

        // Directed program: one instruction, then halt, then a stray byte.
        do_reset(1'b0);
        bq = '{8'h00, 8'h00, 8'h23, 8'h80};
        send(bq);
        end_checks();
        bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send(bq);
        end_checks();
        check("pipe_enable_halt", obs_pe, 1);
`ifdef LOADER_CHECKSUM_EN
        check("checksum_directed", obs_chk, 32'h7FDC_FFFF);
`endif
        bq = '{8'h5A};
        send(bq);
        end_checks();

        // Partial 0xFF lanes are an ordinary instruction.
        do_reset(1'b0);
        bq = '{8'hFF, 8'hFF, 8'hFF, 8'h7F};
        send(bq);
        end_checks();
        check("no_halt_idle", obs_state, S_IDLE);

        // Asynchronous reset with half a word assembled.
        do_reset(1'b0);
        bq = '{8'hAA, 8'hBB};
        send(bq);
        #3 reset_m = 1'b0;
        #1 check("async_rst_state", obs_state, S_IDLE);
        do_reset(1'b0);
        bq = '{8'h01, 8'h02, 8'h03, 8'h04};
        send(bq);
        end_checks();

        // Small memory: overflow, then halt landing in the last slot.
        do_reset(1'b1);
        bq.delete();
        for (int i = 0; i < 4; i++) push_word(bq, 32'h1000_0000 + 32'(i));
        push_word(bq, 32'hFFFF_FFFF);
        send(bq);
        end_checks();
        check("ovf_pe", obs_pe, 0);

        do_reset(1'b1);
        bq.delete();
        for (int i = 0; i < 3; i++) push_word(bq, 32'h2000_0000 + 32'(i));
        push_word(bq, 32'hFFFF_FFFF);
        send(bq);
        end_checks();

        // Random programs on both instances.
        for (int r = 0; r < 8; r++) begin
            do_reset(r[0]);
            bq.delete();
            nw = $urandom_range(1, 7);
            for (int i = 0; i < nw; i++) push_word(bq, rand_word());
            push_word(bq, 32'hFFFF_FFFF);
            repeat ($urandom_range(0, 3)) bq.push_back(8'($urandom));
            send(bq);
            end_checks();
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
